// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, issues single-word reads to instruction memory
// and presents each returned word to the decoder through a valid/ack handshake.
module instr_fetch #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 pc_load,
  input  logic [ADDR_BITS-1:0] pc_load_addr,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_rd_en,
  input  logic [WIDTH-1:0]     mem_rd_data,
  input  logic                 mem_rd_valid,
  output logic [WIDTH-1:0]     instr_out,
  output logic                 instr_valid,
  input  logic                 instr_ack,
  output logic [ADDR_BITS-1:0] instr_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e               state, state_d;
  logic [ADDR_BITS-1:0] pc, pc_d;
  logic [ADDR_BITS-1:0] mem_addr_d;
  logic                 mem_rd_en_d;
  logic [WIDTH-1:0]     instr_out_d;
  logic                 instr_valid_d;
  logic [ADDR_BITS-1:0] instr_pc_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      pc          <= ADDR_BITS'(RESET_PC);
      mem_addr    <= ADDR_BITS'(RESET_PC);
      mem_rd_en   <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      instr_pc    <= ADDR_BITS'(RESET_PC);
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      mem_addr    <= mem_addr_d;
      mem_rd_en   <= mem_rd_en_d;
      instr_out   <= instr_out_d;
      instr_valid <= instr_valid_d;
      instr_pc    <= instr_pc_d;
    end
  end

  // Next-state and next-output logic; a redirect overrides everything, squashing any read in flight
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    mem_addr_d    = mem_addr;
    mem_rd_en_d   = 1'b0;
    instr_out_d   = instr_out;
    instr_valid_d = instr_valid;
    instr_pc_d    = instr_pc;

    if (pc_load) begin
      pc_d          = pc_load_addr;
      instr_valid_d = 1'b0;
      state_d       = FETCH;
    end else begin
      unique case (state)
        FETCH: begin
          if (enable) begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = pc;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (mem_rd_valid) begin
            instr_out_d   = mem_rd_data;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          if (instr_ack && instr_valid) begin
            instr_valid_d = 1'b0;
            pc_d          = pc + ADDR_BITS'(1);
            state_d       = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: reset, sequential fetch, stall, redirect,
// ack+redirect collision, PC wrap and enable gating.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        instr_ack;
  logic [15:0] instr_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.WIDTH(16), .ADDR_BITS(16), .RESET_PC(0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .instr_ack    (instr_ack),
    .instr_pc     (instr_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // From FETCH with enable=1: expect request at addr, return data with 1-cycle latency, expect HOLD
  task automatic fetch(input logic [15:0] addr, input logic [15:0] data);
    tick();
    chk("rd_en_pulse", 16'(mem_rd_en), 16'h1);
    chk("mem_addr", mem_addr, addr);
    mem_rd_valid = 1'b1;
    mem_rd_data  = data;
    tick();
    mem_rd_valid = 1'b0;
    mem_rd_data  = 16'h0;
    chk("rd_en_one_cycle", 16'(mem_rd_en), 16'h0);
    chk("instr_valid", 16'(instr_valid), 16'h1);
    chk("instr_out", instr_out, data);
    chk("instr_pc", instr_pc, addr);
  endtask

  task automatic ack();
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    chk("valid_after_ack", 16'(instr_valid), 16'h0);
  endtask

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b1;
    pc_load      = 1'b0;
    pc_load_addr = 16'h0;
    mem_rd_data  = 16'h0;
    mem_rd_valid = 1'b0;
    instr_ack    = 1'b0;

    // Power-on reset values
    tick();
    tick();
    chk("rst_valid", 16'(instr_valid), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_rd_en", 16'(mem_rd_en), 16'h0);
    chk("rst_instr_pc", instr_pc, 16'h0);
    chk("rst_instr_out", instr_out, 16'h0);
    reset_n = 1'b1;

    // Reset asserted mid-WAIT discards the read
    pc_load = 1'b1; pc_load_addr = 16'h0007;
    tick();
    pc_load = 1'b0;
    tick();
    chk("pre_rst_rd_en", 16'(mem_rd_en), 16'h1);
    chk("pre_rst_addr", mem_addr, 16'h0007);
    reset_n = 1'b0;
    #2;
    chk("async_rst_rd_en", 16'(mem_rd_en), 16'h0);
    chk("async_rst_addr", mem_addr, 16'h0);
    chk("async_rst_valid", 16'(instr_valid), 16'h0);
    tick();
    reset_n = 1'b1;

    // Sequential fetch with a 10-cycle stall on the first word
    fetch(16'h0000, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      mem_rd_valid = (i == 4);
      mem_rd_data  = 16'hBEEF;
      tick();
      chk("stall_out", instr_out, 16'h1234);
      chk("stall_valid", 16'(instr_valid), 16'h1);
      chk("stall_rd_en", 16'(mem_rd_en), 16'h0);
    end
    mem_rd_valid = 1'b0;
    mem_rd_data  = 16'h0;
    ack();
    fetch(16'h0001, 16'h5678);
    ack();
    fetch(16'h0002, 16'h9ABC);
    ack();

    // Redirect in WAIT squashes the concurrent read data
    tick();
    chk("wait_rd_en", 16'(mem_rd_en), 16'h1);
    chk("wait_addr", mem_addr, 16'h0003);
    mem_rd_valid = 1'b1; mem_rd_data = 16'hDEAD;
    pc_load = 1'b1; pc_load_addr = 16'h0040;
    tick();
    mem_rd_valid = 1'b0; mem_rd_data = 16'h0; pc_load = 1'b0;
    chk("squash_valid", 16'(instr_valid), 16'h0);
    chk("squash_rd_en", 16'(mem_rd_en), 16'h0);
    fetch(16'h0040, 16'hAAAA);
    ack();

    // ack and redirect together in HOLD: pc takes the load target
    pc_load = 1'b1; pc_load_addr = 16'h0005;
    tick();
    pc_load = 1'b0;
    chk("load_fetch_no_rd", 16'(mem_rd_en), 16'h0);
    fetch(16'h0005, 16'h5555);
    instr_ack = 1'b1; pc_load = 1'b1; pc_load_addr = 16'h0020;
    tick();
    instr_ack = 1'b0; pc_load = 1'b0;
    chk("ackload_valid", 16'(instr_valid), 16'h0);
    fetch(16'h0020, 16'h2020);
    ack();

    // PC wrap and enable gating; stray ack with valid low is ignored
    pc_load = 1'b1; pc_load_addr = 16'hFFFF;
    tick();
    pc_load = 1'b0;
    fetch(16'hFFFF, 16'h7777);
    enable = 1'b0;
    ack();
    for (int i = 0; i < 5; i++) begin
      instr_ack = (i == 2);
      tick();
      chk("disabled_rd_en", 16'(mem_rd_en), 16'h0);
      chk("disabled_valid", 16'(instr_valid), 16'h0);
    end
    instr_ack = 1'b0;
    enable = 1'b1;
    fetch(16'h0000, 16'h0F0F);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
